// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory access per request, with byte/half lane steering and a bus timeout.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of performing them.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              busy_d, done_d, err_d, misalign_d;
  logic [31:0]       rdata_d;
  logic              mem_req_d, mem_we_d;
  logic [31:0]       mem_addr_d, mem_wdata_d;
  logic [3:0]        mem_be_d;
  logic              mis;

  // Undefined width codes fall through to word.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    be_of = 4'b1111;
    if (st) begin
      case (size_of(f3))
        SZ_B:    be_of = 4'b0001 << lo;
        SZ_H:    be_of = lo[1] ? 4'b1100 : 4'b0011;
        default: be_of = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      SZ_B:    wdata_of = {4{wd[7:0]}};
      SZ_H:    wdata_of = {2{wd[15:0]}};
      default: wdata_of = wd;
    endcase
  endfunction

  // funct3[2] selects zero-extension (BU/HU).
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = d[{lo[1], 4'b0000} +: 16];
    case (size_of(f3))
      SZ_B:    load_ext = {{24{b[7] & ~f3[2]}}, b};
      SZ_H:    load_ext = {{16{h[15] & ~f3[2]}}, h};
      default: load_ext = d;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis = 1'b0;
    case (size_of(funct3))
      SZ_H:    mis = addr[0];
      SZ_W:    mis = (addr[1:0] != 2'b00);
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  // Next-state and next-output logic; every output register is loaded from its _d value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    done_d      = 1'b0;
    err_d       = 1'b0;
    misalign_d  = 1'b0;
    rdata_d     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          funct3_d  = funct3;
          addr_lo_d = addr[1:0];
          cnt_d     = '0;
          if (mis) begin
            state_d    = DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = be_of(is_store, funct3, addr[1:0]);
            mem_wdata_d = wdata_of(funct3, wdata);
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = mem_we ? 32'h0 : load_ext(funct3_q, addr_lo_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      misalign  <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      misalign  <= misalign_d;
      rdata     <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed spec vectors plus randomized accesses against an arithmetic reference model.
// Honours LSU_MISALIGN_TRAP_EN in the same way as the design build.
module tb_lsu;

  localparam int TO_MAIN = 16;
  localparam int TO_SHORT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start4;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_ack, ack4;
  logic [31:0] mem_rdata;

  logic        busy, done, err, misalign, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        t4_busy, t4_done, t4_err, t4_misalign, t4_mem_req, t4_mem_we;
  logic [31:0] t4_rdata, t4_mem_addr, t4_mem_wdata;
  logic [3:0]  t4_mem_be;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu #(.TIMEOUT_CYCLES(TO_SHORT)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(t4_busy), .done(t4_done), .rdata(t4_rdata), .err(t4_err),
    .misalign(t4_misalign), .mem_req(t4_mem_req), .mem_we(t4_mem_we), .mem_addr(t4_mem_addr),
    .mem_wdata(t4_mem_wdata), .mem_be(t4_mem_be), .mem_ack(ack4), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes; unknown codes act as a word.
  function automatic int size_b(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (size_b(f3) == 2 && a[0]) || (size_b(f3) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'hF;
    if (size_b(f3) == 1) return 4'(1 << a[1:0]);
    if (size_b(f3) == 2) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (size_b(f3) == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (size_b(f3) == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (size_b(f3) == 1) begin
      v = (d >> (8 * a[1:0])) & 32'hFF;
      if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size_b(f3) == 2) begin
      v = (d >> (16 * a[1])) & 32'hFFFF;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // One complete request on the main instance; ack arrives in REQ cycle dly (dly >= TO_MAIN means never).
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] mrd, output logic [31:0] rd_seen);
    bit          done_seen;
    bit          e_err;
    logic [31:0] e_rdata;
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (model_mis(f3, a)) begin
      chk("trap_done", done, 1'b1);
      chk("trap_misalign", misalign, 1'b1);
      chk("trap_no_req", mem_req, 1'b0);
      chk("trap_rdata", rdata, 32'h0);
      chk("trap_err", err, 1'b0);
    end else begin
      done_seen = 1'b0;
      for (int k = 0; k < TO_MAIN && !done_seen; k++) begin
        chk("req_mem_req", mem_req, 1'b1);
        chk("req_busy", busy, 1'b1);
        chk("req_done", done, 1'b0);
        chk("req_mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("req_mem_we", mem_we, st);
        chk("req_mem_be", 32'(mem_be), 32'(model_be(st, f3, a)));
        if (st) chk("req_mem_wdata", mem_wdata, model_wdata(f3, wd));
        mem_ack = (k == dly);
        mem_rdata = (k == dly) ? mrd : $urandom;
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1;
          addr = $urandom;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        start = 1'b0;
        if (k == dly) done_seen = 1'b1;
      end
      e_err = (dly >= TO_MAIN);
      e_rdata = (st || e_err) ? 32'h0 : model_load(f3, a, mrd);
      chk("done_pulse", done, 1'b1);
      chk("done_err", err, e_err);
      chk("done_rdata", rdata, e_rdata);
      chk("done_misalign", misalign, 1'b0);
      chk("done_mem_req", mem_req, 1'b0);
    end
    rd_seen = rdata;
    chk("done_busy", busy, 1'b1);
    // Both start and ack are presented during DONE and must be ignored.
    start = 1'($urandom_range(0, 1));
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    mem_ack = 1'b0;
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_mem_req", mem_req, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  f3;
    logic [2:0]  codes [5];
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100; codes[4] = 3'b101;
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; is_store = 1'b0; funct3 = 3'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; ack4 = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LB at 0x103, top byte 0x80 sign-extends.
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FFFF, rd);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    // SH at 0x202 replicates the halfword into the upper lanes.
    access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 32'h5555_5555, rd);
    chk("sh_rdata", rd, 32'h0);
    // LHU with ack after five waiting REQ cycles.
    access(1'b0, 3'b101, 32'h10, 32'h0, 5, 32'h1234_F00D, rd);
    chk("lhu_rdata", rd, 32'h0000_F00D);
    // LW at 0x102: trapped or performed depending on build.
    access(1'b0, 3'b010, 32'h102, 32'h0, 1, 32'hDEAD_BEEF, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_rdata", rd, 32'h0);
`else
    chk("lw_mis_rdata", rd, 32'hDEAD_BEEF);
`endif

    // Timeout on the short-timeout instance: done with err after exactly four REQ cycles.
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 0; k < TO_SHORT; k++) begin
      chk("to_req", t4_mem_req, 1'b1);
      chk("to_no_done", t4_done, 1'b0);
      @(posedge clk); #1;
    end
    chk("to_done", t4_done, 1'b1);
    chk("to_err", t4_err, 1'b1);
    chk("to_rdata", t4_rdata, 32'h0);
    chk("to_mem_req", t4_mem_req, 1'b0);
    @(posedge clk); #1;
    chk("to_idle", t4_busy, 1'b0);

    // Reset in REQ, then a late ack: the access is abandoned silently.
    is_store = 1'b0; funct3 = 3'b000; addr = 32'h80; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rr_req", mem_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    chk("rr_mem_req", mem_req, 1'b0);
    chk("rr_busy", busy, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rr_no_done", done, 1'b0);
    chk("rr_busy2", busy, 1'b0);
    chk("rr_mem_req2", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("rr_no_done2", done, 1'b0);

    // Randomized accesses, including occasional undefined width codes and timeouts.
    for (int i = 0; i < 60; i++) begin
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : codes[$urandom_range(0, 4)];
      access(1'($urandom_range(0, 1)), f3, $urandom, $urandom,
             int'($urandom_range(0, TO_MAIN + 2)), $urandom, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
